// File: rtl/cnc_readback.sv
// cnc_readback: PLX local-bus read responder with position counter, timestamp and sticky events.
module cnc_readback #(
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [31:0] ID_VALUE    = 32'h5A20_0C0C
) (
    input  logic        LClk,
    input  logic        rst,
    input  logic        ADS,
    input  logic        LRD,
    input  logic [31:0] LAD_in,
    output logic [31:0] LAD_out,
    output logic        LAD_oe,
    output logic        READY,
    input  logic        ST_CLK,
    input  logic        ST_DIR,
    input  logic        ST_ENB,
    input  logic        ST_DIS,
    input  logic        SP_BRK,
    input  logic        SP_DIR,
    input  logic        SP_DIS,
    input  logic        pos_clr
);
    localparam logic [3:0] WS = 4'(WAIT_STATES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DRIVE, S_TURN} state_t;

    state_t      state_q;
    logic [3:0]  wcnt_q;
    logic [2:0]  addr_q;
    logic        armed_q, st_clk_q, wrap_q, dis_q, clr4_q;
    logic [31:0] pos_q, snap_q, ts_q, lad_out_q;
    logic        lad_oe_q, ready_q;
    logic        step, wrap_d, dis_d, drive_go, ev_clr;
    logic [31:0] pos_d, rd_d;
    logic        unused_lad;

    assign unused_lad = ^{LAD_in[31:5], LAD_in[1:0]};

    always_comb begin
        step     = ST_CLK & ~st_clk_q;
        pos_d    = pos_clr ? 32'd0 : step ? (ST_DIR ? pos_q + 32'd1 : pos_q - 32'd1) : pos_q;
        ev_clr   = (state_q == S_DRIVE) && clr4_q;
        // a crossing only counts when the counter really moves, not when pos_clr overrides it
        wrap_d   = (step & ~pos_clr & (ST_DIR ? pos_q == 32'h7FFF_FFFF : pos_q == 32'h8000_0000))
                   | (wrap_q & ~ev_clr);
        dis_d    = (step & ST_DIS) | (dis_q & ~ev_clr);
        drive_go = (state_q == S_WAIT) && !LRD && (wcnt_q == 4'd0);
        rd_d     = 32'd0;
        case (addr_q)
            3'd0: rd_d = ID_VALUE;
            3'd1: rd_d = pos_q;
            3'd2: rd_d = {25'd0, SP_DIR, SP_DIS, SP_BRK, ST_DIR, ST_DIS, ST_ENB, ST_CLK};
            3'd3: rd_d = ts_q;
            3'd4: rd_d = {30'd0, dis_q, wrap_q};
            3'd5: rd_d = snap_q;
            default: rd_d = 32'd0;
        endcase
    end

    always_ff @(posedge LClk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            wcnt_q    <= 4'd0;
            addr_q    <= 3'd0;
            armed_q   <= 1'b1;
            st_clk_q  <= 1'b0;
            wrap_q    <= 1'b0;
            dis_q     <= 1'b0;
            clr4_q    <= 1'b0;
            pos_q     <= 32'd0;
            snap_q    <= 32'd0;
            ts_q      <= 32'd0;
            lad_out_q <= 32'd0;
            lad_oe_q  <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            st_clk_q <= ST_CLK;
            pos_q    <= pos_d;
            wrap_q   <= wrap_d;
            dis_q    <= dis_d;
            ts_q     <= ts_q + 32'd1;
            lad_oe_q <= drive_go;
            ready_q  <= !drive_go;
            if (!ADS) addr_q <= LAD_in[4:2];
            if (drive_go) begin
                lad_out_q <= rd_d;
                clr4_q    <= addr_q == 3'd4;
                if (addr_q == 3'd1) snap_q <= pos_q;
            end
            case (state_q)
                S_IDLE:
                    if (LRD) armed_q <= 1'b1;
                    else if (armed_q) begin
                        armed_q <= 1'b0;
                        wcnt_q  <= WS;
                        state_q <= S_WAIT;
                    end
                S_WAIT:
                    if (LRD) state_q <= S_IDLE;
                    else if (wcnt_q == 4'd0) state_q <= S_DRIVE;
                    else wcnt_q <= wcnt_q - 4'd1;
                S_DRIVE: state_q <= S_TURN;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign LAD_out = lad_out_q;
    assign LAD_oe  = lad_oe_q;
    assign READY   = ready_q;
endmodule

// File: tb/tb_cnc_readback.sv
// tb_cnc_readback: scoreboard bench for cnc_readback with W=1 (scoreboarded), W=3 and W=0 instances.
module tb_cnc_readback;
    logic        LClk = 1'b0, rst = 1'b0, ADS = 1'b1;
    logic        LRD1 = 1'b1, LRD3 = 1'b1, LRD0 = 1'b1;
    logic [31:0] LAD_in = '0;
    logic        ST_CLK = 0, ST_DIR = 0, ST_ENB = 0, ST_DIS = 0;
    logic        SP_BRK = 0, SP_DIR = 0, SP_DIS = 0, pos_clr = 0;
    logic [31:0] OUT1, OUT3, OUT0;
    logic        OE1, OE3, OE0, READY1, READY3, READY0;
    logic [31:0] sb[$];
    logic [31:0] ts_m;
    int          tests = 0, fails = 0, drv_cnt = 0;
    localparam logic [31:0] ID = 32'h5A20_0C0C;

    always #5 LClk = ~LClk;

    cnc_readback #(.WAIT_STATES(1)) u1 (.LClk(LClk), .rst(rst), .ADS(ADS), .LRD(LRD1), .LAD_in(LAD_in),
        .LAD_out(OUT1), .LAD_oe(OE1), .READY(READY1), .ST_CLK(ST_CLK), .ST_DIR(ST_DIR), .ST_ENB(ST_ENB),
        .ST_DIS(ST_DIS), .SP_BRK(SP_BRK), .SP_DIR(SP_DIR), .SP_DIS(SP_DIS), .pos_clr(pos_clr));
    cnc_readback #(.WAIT_STATES(3)) u3 (.LClk(LClk), .rst(rst), .ADS(ADS), .LRD(LRD3), .LAD_in(LAD_in),
        .LAD_out(OUT3), .LAD_oe(OE3), .READY(READY3), .ST_CLK(ST_CLK), .ST_DIR(ST_DIR), .ST_ENB(ST_ENB),
        .ST_DIS(ST_DIS), .SP_BRK(SP_BRK), .SP_DIR(SP_DIR), .SP_DIS(SP_DIS), .pos_clr(pos_clr));
    cnc_readback #(.WAIT_STATES(0)) u0 (.LClk(LClk), .rst(rst), .ADS(ADS), .LRD(LRD0), .LAD_in(LAD_in),
        .LAD_out(OUT0), .LAD_oe(OE0), .READY(READY0), .ST_CLK(ST_CLK), .ST_DIR(ST_DIR), .ST_ENB(ST_ENB),
        .ST_DIS(ST_DIS), .SP_BRK(SP_BRK), .SP_DIR(SP_DIR), .SP_DIS(SP_DIS), .pos_clr(pos_clr));

    always @(posedge LClk or negedge rst) ts_m <= !rst ? 32'd0 : ts_m + 32'd1;

    function automatic void chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endfunction

    always @(negedge LClk) begin
        chk("oe_matches_drive", {31'd0, OE1}, {31'd0, ~READY1});
        if (!READY1) begin
            drv_cnt++;
            chk("sb_nonempty", {31'd0, sb.size() != 0}, 32'd1);
            if (sb.size() != 0) chk("rd_data", OUT1, sb.pop_front());
        end
    end

    task automatic read1(input logic [2:0] a, input logic [31:0] e, input bit use_ts, input bit drv_step);
        int lat;
        @(negedge LClk); ADS = 0; LAD_in = {27'd0, a, 2'b00};
        @(negedge LClk); ADS = 1; LAD_in = '0;
        sb.push_back(use_ts ? ts_m + 32'd2 : e);
        LRD1 = 0; lat = 0;
        for (int i = 1; i <= 10 && lat == 0; i++) begin
            @(negedge LClk);
            if (!READY1) lat = i;
        end
        chk("rd_latency_w1", lat, 3);
        if (drv_step) begin ST_DIR = 1; ST_DIS = 1; ST_CLK = 1; end
        @(negedge LClk); ST_CLK = 0; ST_DIS = 0; LRD1 = 1;
        chk("turn_ready", {31'd0, READY1}, 32'd1);
        chk("turn_oe", {31'd0, OE1}, 32'd0);
        @(negedge LClk);
    endtask

    task automatic rdx(input bit w3, input logic [2:0] a, input bit rst_mid, output logic [31:0] d, output int lat);
        @(negedge LClk); ADS = 0; LAD_in = {27'd0, a, 2'b00};
        @(negedge LClk); ADS = 1; LAD_in = '0;
        if (w3) LRD3 = 0; else LRD0 = 0;
        lat = 0; d = '0;
        for (int i = 1; i <= 12 && lat == 0; i++) begin
            @(negedge LClk);
            if (!(w3 ? READY3 : READY0)) begin lat = i; d = w3 ? OUT3 : OUT0; end
        end
        if (rst_mid) begin
            rst = 0; #1;
            chk("rst_mid_ready", {31'd0, READY0}, 32'd1);
            chk("rst_mid_oe", {31'd0, OE0}, 32'd0);
            chk("rst_mid_out", OUT0, 32'd0);
        end
        @(negedge LClk); LRD3 = 1; LRD0 = 1; rst = 1;
        @(negedge LClk);
    endtask

    task automatic step(input logic dir, input logic dis);
        @(negedge LClk); ST_DIR = dir; ST_DIS = dis; ST_CLK = 1;
        @(negedge LClk); ST_CLK = 0; ST_DIS = 0;
    endtask

    initial begin
        logic [31:0] d;
        int lat, d0, lows;
        repeat (3) @(negedge LClk);
        chk("reset_ready", {31'd0, READY1}, 32'd1);
        chk("reset_oe", {31'd0, OE1}, 32'd0);
        chk("reset_out", OUT1, 32'd0);
        rst = 1;
        read1(3'd0, ID, 0, 0);
        read1(3'd3, 0, 1, 0);
        ST_ENB = 1; SP_BRK = 1; SP_DIR = 1;
        read1(3'd2, 32'h52, 0, 0);
        ST_ENB = 0; SP_BRK = 0; SP_DIR = 0;
        read1(3'd6, 0, 0, 0);
        read1(3'd7, 0, 0, 0);
        repeat (5) step(1, 0);
        repeat (2) step(0, 0);
        read1(3'd5, 0, 0, 0);
        read1(3'd1, 3, 0, 0);
        read1(3'd5, 3, 0, 0);
        read1(3'd4, 0, 0, 0);
        @(negedge LClk); pos_clr = 1; ST_DIR = 1; ST_CLK = 1;
        @(negedge LClk); pos_clr = 0; ST_CLK = 0;
        read1(3'd1, 0, 0, 0);
        @(negedge LClk); force u1.pos_q = 32'h7FFF_FFFF;
        @(negedge LClk); release u1.pos_q;
        step(1, 0);
        read1(3'd1, 32'h8000_0000, 0, 0);
        read1(3'd4, 32'h1, 0, 0);
        read1(3'd4, 32'h0, 0, 0);
        step(1, 1);
        read1(3'd4, 32'h2, 0, 1);
        read1(3'd4, 32'h2, 0, 0);
        read1(3'd4, 32'h0, 0, 0);
        @(negedge LClk); ADS = 0; LAD_in = '0;
        @(negedge LClk); ADS = 1;
        sb.push_back(ID); d0 = drv_cnt; LRD1 = 0;
        repeat (20) @(negedge LClk);
        LRD1 = 1;
        repeat (4) @(negedge LClk);
        chk("held_lrd_one_drive", drv_cnt - d0, 1);
        @(negedge LClk); ADS = 0; LAD_in = {27'd0, 3'd4, 2'b00};
        @(negedge LClk); ADS = 1; LAD_in = '0; LRD3 = 0; lows = 0;
        repeat (2) @(negedge LClk);
        LRD3 = 1;
        repeat (8) begin @(negedge LClk); if (!READY3) lows++; end
        chk("abort_no_ready", lows, 0);
        rdx(1, 3'd4, 0, d, lat);
        chk("w3_latency", lat, 5);
        chk("abort_kept_events", d, 32'h2);
        rdx(0, 3'd0, 0, d, lat);
        chk("w0_latency", lat, 2);
        chk("w0_data", d, ID);
        rdx(0, 3'd0, 1, d, lat);
        chk("w0_latency_pre_rst", lat, 2);
        read1(3'd3, 0, 1, 0);
        read1(3'd1, 0, 0, 0);
        read1(3'd4, 0, 0, 0);
        repeat (3) @(negedge LClk);
        chk("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/cnc_readback.md
# cnc_readback

Local-bus read responder for the 5I20 CNC controller. It is the read-side companion of the write-side command decoder on the same PLX local bus (LClk, ADS, LAD). It latches the register address on ADS, inserts programmable wait states, drives LAD with a snapshotted register value, and signals completion with READY. It also maintains the stepper position counter, a free-running timestamp and sticky fault flags, so the host can read back motion state.

## Interface
- WAIT_STATES, 1, wait cycles between read request and data drive; legal range 0..15
- ID_VALUE, 32'h5A20_0C0C, constant returned at register 0
- LClk  in  1  local bus clock; all logic rising-edge
- rst  in  1  reset, asynchronous, active-low
- ADS  in  1  address strobe, active-low; LAD holds the address while low
- LRD  in  1  read request, active-low
- LAD_in  in  32  local address/data bus, input side
- LAD_out  out  32  read data to bus
- LAD_oe  out  1  drive enable for LAD_out; the top level builds the tristate
- READY  out  1  transfer done, active-low
- ST_CLK, ST_DIR, ST_ENB, ST_DIS  in  1 each  stepper signals from the command decoder
- SP_BRK, SP_DIR, SP_DIS  in  1 each  spindle signals from the command decoder
- pos_clr  in  1  synchronous clear of the position counter, active-high

## Operation
- Address: on each edge with ADS=0, latch addr <= LAD_in[4:2]. Otherwise hold.
- Register map (addr):
  - 0: ID_VALUE
  - 1: position (signed 32)
  - 2: status {25'b0, SP_DIR, SP_DIS, SP_BRK, ST_DIR, ST_DIS, ST_ENB, ST_CLK}
  - 3: timestamp
  - 4: events {30'b0, dis_step, wrap}; read-to-clear
  - 5: position snapshot taken at the last addr-1 read
  - 6, 7: 32'h0000_0000
- Position counter:
  - st_clk_d registers ST_CLK. A rise (ST_CLK=1, st_clk_d=0) is one step.
  - On a step: position +1 if ST_DIR=1, else -1. Arithmetic is modulo 2^32.
  - pos_clr has priority over a step in the same cycle.
- Events (sticky):
  - wrap sets on a step crossing 32'h7FFF_FFFF<->32'h8000_0000 in either direction.
  - dis_step sets on a step while ST_DIS=1.
  - Both are cleared by the DRIVE cycle of an addr-4 read. Set wins over clear in the same cycle.
- Timestamp: free-running 32-bit up-counter from reset; wraps to 0.
- FSM states: IDLE, WAIT, DRIVE, TURN.
  - IDLE: if LRD=0 and armed=1, load wcnt <= WAIT_STATES and go to WAIT.
  - WAIT: if LRD=1, abort to IDLE with no side effects. Else if wcnt=0, go to DRIVE; else decrement wcnt.
  - DRIVE (1 cycle): go to TURN.
  - TURN (1 cycle): go to IDLE.
- armed: cleared on entry to WAIT; set when LRD=1 is sampled in IDLE. A held-low LRD therefore gets exactly one response.
- Data path: on the edge entering DRIVE, LAD_out <= mux(addr). If addr=1, snapshot <= position on the same edge.

## Timing
- Reset values:
  - LAD_out=0, LAD_oe=0, READY=1
  - position=0, snapshot=0, timestamp=0, events=0
  - addr=0, state=IDLE, armed=1, st_clk_d=0
- All outputs are registered. READY=0 and LAD_oe=1 exactly during the DRIVE state. In all other states READY=1 and LAD_oe=0.
- Latency: LRD sampled low at edge k (IDLE) -> DRIVE visible after edge k+W+1, where W=WAIT_STATES. TURN follows after k+W+2 and IDLE after k+W+3.
- TURN is a mandatory bus-turnaround cycle with LAD_oe=0.
- Step detection is 1 cycle after the ST_CLK rise; position updates on that edge.
- Reset asserted mid-transfer immediately forces LAD_oe=0 and READY=1, and returns the FSM to IDLE.
- ADS during WAIT updates addr. The value driven is the addr present at DRIVE entry.

## Test plan
- Reset, then read addr 0 with W=1: LRD low at edge 10 -> READY=0 and LAD_oe=1 only in cycle after edge 12, LAD_out=32'h5A20_0C0C; LAD_oe=0 in TURN.
- 5 ST_CLK rises with ST_DIR=1, then 2 with ST_DIR=0 -> read addr 1 = 3 and addr 5 = 3. Pulse pos_clr together with a step -> position=0.
- Position at 32'h7FFF_FFFF plus one step up -> 32'h8000_0000 and wrap=1. Read addr 4 = 32'h1; a second read = 32'h0.
- Step with ST_DIS=1 in the same cycle as the addr-4 DRIVE -> returned value shows the old flags and dis_step remains 1 afterwards.
- LRD held low for 20 cycles -> exactly one DRIVE pulse. LRD raised during WAIT (W=3) -> no READY, no event clear.
- W=0: LRD low at edge k -> DRIVE after edge k+1. Assert rst during DRIVE -> LAD_oe=0 and READY=1 immediately, timestamp=0.
